// File: rtl/crc_serial_tx.sv
// Serial CRC link transmitter: frames a parallel word as start bit, data MSB first,
// then the CRC remainder MSB first, on a single registered line.
`timescale 1ns/1ps

module crc_serial_tx #(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 4,
    parameter logic [CRC_W-1:0]  POLY   = 4'b0011
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              LOAD,
    input  logic [DATA_W-1:0] DIN,
    output logic              SDO,
    output logic              BUSY,
    output logic              DONE,
    output logic [CRC_W-1:0]  CRC_OUT
);

    localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, CRC} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CRC_W-1:0]    tail_q, tail_d;
    logic [CRC_W-1:0]    crc_out_q, crc_out_d;
    logic                sdo_q, sdo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                present_data;
    logic                present_crc;
    logic                fb;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            crc_q     <= '0;
            tail_q    <= '0;
            crc_out_q <= '0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            tail_q    <= tail_d;
            crc_out_q <= crc_out_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The counter indexes the bit currently on the line within DATA or CRC.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = CRC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CRC: begin
                if (cnt_q == CRC_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register inputs are chosen from the transition so every output lands on the edge.
    always_comb begin
        shift_d      = shift_q;
        crc_d        = crc_q;
        tail_d       = tail_q;
        crc_out_d    = crc_out_q;
        sdo_d        = 1'b0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == CRC) && (cnt_d == CRC_LAST);
        present_data = (state_q == START) || ((state_q == DATA) && (state_d == DATA));
        present_crc  = (state_d == CRC);
        fb           = shift_q[DATA_W-1] ^ crc_q[CRC_W-1];

        if ((state_q == IDLE) && (state_d == START)) begin
            shift_d = DIN;
            crc_d   = '0;
            tail_d  = '0;
            sdo_d   = 1'b1;
        end

        if (present_data) begin
            sdo_d   = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            crc_d   = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end

        // Tail collects the remainder as it leaves so the full value survives the shift-out.
        if (present_crc) begin
            sdo_d  = crc_q[CRC_W-1];
            crc_d  = {crc_q[CRC_W-2:0], 1'b0};
            tail_d = {tail_q[CRC_W-2:0], crc_q[CRC_W-1]};
        end

        if (done_d) begin
            crc_out_d = tail_d;
        end
    end

    assign SDO     = sdo_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign CRC_OUT = crc_out_q;

endmodule

// File: tb/tb_crc_serial_tx.sv
// Directed self-checking bench for crc_serial_tx at default parameters (8 data bits, x^4+x+1).
`timescale 1ns/1ps

module tb_crc_serial_tx;

    localparam int PERIOD = 40;

    logic       CLK  = 1'b0;
    logic       CLR  = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] DIN  = 8'h00;
    logic       SDO;
    logic       BUSY;
    logic       DONE;
    logic [3:0] CRC_OUT;

    int  checks   = 0;
    int  failures = 0;
    time lastEdge = 0;

    crc_serial_tx dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .LOAD    (LOAD),
        .DIN     (DIN),
        .SDO     (SDO),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .CRC_OUT (CRC_OUT)
    );

    always #(PERIOD/2) CLK = ~CLK;

    always @(posedge CLK) lastEdge = $time;

    // Any line transition outside reset must sit exactly on a rising edge.
    always @(SDO) begin
        if (CLR) checkOutput("sdo_on_edge", 32'(($time == lastEdge) && CLK), 32'd1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic stepEdge();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] din);
        LOAD = 1'b1;
        DIN  = din;
    endtask

    // Walks edges k..k+13 of one frame; pattern[13] is the bit expected at edge k.
    task automatic runFrame(input string tag, input logic [13:0] pattern, input logic [3:0] crc,
                            input bit holdLoad, input bit pulseLoad);
        for (int i = 0; i < 14; i++) begin
            stepEdge();
            checkOutput({tag, "_sdo"},  32'(SDO),  32'(pattern[13-i]));
            checkOutput({tag, "_busy"}, 32'(BUSY), (i <= 12) ? 32'd1 : 32'd0);
            checkOutput({tag, "_done"}, 32'(DONE), (i == 12) ? 32'd1 : 32'd0);
            if (i == 12) checkOutput({tag, "_crc"}, 32'(CRC_OUT), 32'(crc));
            if (!holdLoad) LOAD = pulseLoad && ((i == 2) || (i == 11));
            if (pulseLoad && ((i == 2) || (i == 11))) DIN = 8'hFF;
        end
    endtask

    initial begin
        #(PERIOD * 3000);
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #(PERIOD * 2 + 5);
        checkOutput("rst_sdo",  32'(SDO),     32'd0);
        checkOutput("rst_busy", 32'(BUSY),    32'd0);
        checkOutput("rst_done", 32'(DONE),    32'd0);
        checkOutput("rst_crc",  32'(CRC_OUT), 32'd0);
        CLR = 1'b1;
        stepEdge();
        checkOutput("idle_sdo", 32'(SDO), 32'd0);

        applyStimulus(8'hA5);
        runFrame("a5", 14'b1_10100101_1011_0, 4'hB, 1'b0, 1'b0);

        applyStimulus(8'h00);
        runFrame("zero", 14'b1_00000000_0000_0, 4'h0, 1'b0, 1'b0);

        applyStimulus(8'hA5);
        runFrame("a5_ignore", 14'b1_10100101_1011_0, 4'hB, 1'b0, 1'b1);

        applyStimulus(8'h01);
        runFrame("hold1", 14'b1_00000001_0011_0, 4'h3, 1'b1, 1'b0);
        runFrame("hold2", 14'b1_00000001_0011_0, 4'h3, 1'b1, 1'b0);
        LOAD = 1'b0;
        stepEdge();
        stepEdge();
        checkOutput("post_hold_sdo", 32'(SDO),  32'd0);
        checkOutput("post_hold_busy", 32'(BUSY), 32'd0);

        applyStimulus(8'hA5);
        for (int i = 0; i < 5; i++) begin
            stepEdge();
            LOAD = 1'b0;
        end
        @(posedge CLK);
        #10;
        checkOutput("pre_clr_busy", 32'(BUSY), 32'd1);
        CLR = 1'b0;
        #1;
        checkOutput("clr_sdo",  32'(SDO),     32'd0);
        checkOutput("clr_busy", 32'(BUSY),    32'd0);
        checkOutput("clr_done", 32'(DONE),    32'd0);
        checkOutput("clr_crc",  32'(CRC_OUT), 32'd0);
        #10;
        CLR = 1'b1;
        stepEdge();
        checkOutput("after_clr_idle", 32'(SDO), 32'd0);
        applyStimulus(8'hA5);
        runFrame("a5_after_clr", 14'b1_10100101_1011_0, 4'hB, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_serial_tx.md
Name: crc_serial_tx

Overview:
- Transmit-side serializer for the serial CRC link. Sits directly upstream of the line-side D flip-flop stage and drives that flop's D input.
- Accepts a parallel data word on a load strobe and emits one frame on a single registered serial line: start bit, data bits MSB first, then CRC remainder MSB first.
- The downstream receiver stage re-clocks the line through a CLK/CLR flop. SDO must therefore be glitch-free and change only on the rising CLK edge.

Parameters:
- DATA_W, 8, data word width in bits (>=2).
- CRC_W, 4, CRC remainder width in bits (>=2).
- POLY, 4'b0011, generator polynomial low-order coefficients, CRC_W bits wide; the implicit x^CRC_W term is omitted. Default is x^4+x+1.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  reset; asynchronous, active-low.
- LOAD  input  1  request to send DIN; sampled on the rising CLK edge, acted on only in IDLE.
- DIN  input  DATA_W  parallel data word; sampled on the same edge that accepts LOAD.
- SDO  output  1  registered serial line to the downstream flop.
- BUSY  output  1  high while a frame is in progress.
- DONE  output  1  one-cycle pulse on the final CRC bit.
- CRC_OUT  output  CRC_W  final remainder of the current or last frame; held until the next accepted LOAD.

Behaviour:
- Reset: CLR low asynchronously forces the state to IDLE and clears SDO, BUSY, DONE, CRC_OUT, the shift register, the CRC register and the bit counter to 0. This applies mid-frame: the frame is abandoned with no partial CRC, and SDO returns to 0 immediately.
- Line idle level: SDO=0 whenever the state is IDLE.
- FSM states: IDLE, START, DATA, CRC.
  - IDLE: if LOAD=1 at edge k, capture DIN into the shift register, clear the CRC register, and enter START. SDO=1 and BUSY=1 from edge k.
  - START: lasts 1 cycle, then enters DATA. On edge k+1, SDO = DIN[DATA_W-1].
  - DATA: DATA_W cycles (edges k+1..k+DATA_W). Each cycle presents the next data bit MSB first and updates the CRC with that bit. After the last data bit, enter CRC.
  - CRC: CRC_W cycles (edges k+DATA_W+1..k+DATA_W+CRC_W). Shifts out the remainder MSB first.
  - DONE=1 for exactly the cycle of the last CRC bit; CRC_OUT is updated on that same edge.
  - Next edge (k+DATA_W+CRC_W+1): return to IDLE with SDO=0, BUSY=0, DONE=0.
- Frame length: 1+DATA_W+CRC_W cycles (13 at defaults).
- CRC update per data bit d (serial LFSR, initial value 0):
  - fb = d XOR crc[CRC_W-1]
  - crc_next = {crc[CRC_W-2:0],1'b0} XOR (fb ? POLY : 0)
  - The result equals DIN*x^CRC_W mod G(x).
- In the CRC state the CRC register shifts left with zero fill and SDO takes crc[CRC_W-1]. No further LFSR feedback is applied.
- LOAD while BUSY=1, including the DONE cycle, is ignored. DIN changes while BUSY=1 have no effect.
- LOAD held high continuously: a new frame starts on the first edge in IDLE. There is one idle cycle (SDO=0) between back-to-back frames.
- The bit counter is sized to cover max(DATA_W,CRC_W) and must not wrap within a state.
- No clock-gating or combinational path from any input to SDO. All outputs are registered.

Test Plan:
- Reset, then LOAD=1, DIN=8'hA5 at edge k -> SDO sequence from edge k: 1, 1,0,1,0,0,1,0,1, 1,0,1,1, then 0. DONE high only on cycle k+12. CRC_OUT=4'hB. BUSY high for cycles k..k+12.
- DIN=8'h00 -> SDO: 1, eight 0s, then 0000. CRC_OUT=4'h0. DONE still pulses at k+12.
- LOAD pulsed again at cycles k+3 and k+12 during the A5 frame with DIN=8'hFF -> ignored. Frame bits unchanged; SDO=0 at k+13.
- LOAD held high with DIN=8'h01 -> frames start at k and k+14. CRC_OUT=4'h3. SDO=0 at cycle k+13.
- CLR asserted low asynchronously mid-DATA (between edges, at cycle k+5) -> SDO, BUSY, DONE and CRC_OUT go to 0 immediately. After release, a LOAD with DIN=8'hA5 produces the full correct frame.
- Every SDO transition coincides with a CLK rising edge. Measured against the downstream flop, SDO is stable for at least 16 ns before and 5 ns after each rising edge.
